// File: rtl/p2s_pkg.sv
// Shared types and helpers for the parallel2serial / serial2parallel loopback pair.
package p2s_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial2parallel_if.sv
// Framed serial input plus valid/ready word output of the deserializer.
interface serial2parallel_if #(
  parameter int WIDTH = p2s_pkg::DEFAULT_WIDTH
);

  logic             serial_start;
  logic             serial_in;
  logic             serial_end;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;
  logic             overrun;

  modport master (
    output serial_start, serial_in, serial_end, out_ready,
    input  parallel_out, out_valid, frame_err, overrun
  );

  modport slave (
    input  serial_start, serial_in, serial_end, out_ready,
    output parallel_out, out_valid, frame_err, overrun
  );

endinterface

// File: rtl/s2p_out_reg.sv
// One-entry output holding register with valid/ready handshake and overrun detection.
module s2p_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             overrun_out
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  // A new word may only replace the held one if the held one leaves this cycle.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      if (!valid_q || out_ready) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign overrun_out = overrun_q;

endmodule

// File: rtl/serial2parallel.sv
// Framed serial-to-parallel deserializer: framing FSM and shift register feeding s2p_out_reg.
// Optional error counter output enabled by defining SERIAL2PARALLEL_ERR_CNT_EN.
module serial2parallel
  import p2s_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  serial2parallel_if.slave bus
`ifdef SERIAL2PARALLEL_ERR_CNT_EN
  ,
  output logic [7:0]      err_count
`endif
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  ONE      = CW'(1);

  p2s_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             complete;
  logic             overrun_pulse;

  function automatic logic [WIDTH-1:0] insert_bit(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) begin
      return {cur[WIDTH-2:0], b};
    end else begin
      return {b, cur[WIDTH-1:1]};
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (bus.serial_start && !bus.serial_end) begin
          shift_d = insert_bit(shift_q, bus.serial_in);
          cnt_d   = ONE;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = insert_bit(shift_q, bus.serial_in);
        if (bus.serial_start) begin
          cnt_d = ONE;
        end else if (cnt_q == LAST_IDX || bus.serial_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // A frame is good only when serial_end lands exactly on the last bit.
  always_comb begin
    frame_err_d = 1'b0;
    complete    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.serial_end) begin
          frame_err_d = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.serial_start) begin
          frame_err_d = 1'b1;
        end else if (cnt_q == LAST_IDX) begin
          if (bus.serial_end) begin
            complete = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (bus.serial_end) begin
          frame_err_d = 1'b1;
        end
      end
      default: begin
        frame_err_d = 1'b0;
      end
    endcase
  end

  s2p_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (complete),
    .load_data   (shift_d),
    .out_ready   (bus.out_ready),
    .data_out    (bus.parallel_out),
    .valid_out   (bus.out_valid),
    .overrun_out (overrun_pulse)
  );

  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_pulse;

`ifdef SERIAL2PARALLEL_ERR_CNT_EN
  logic [7:0] err_count_q, err_count_d;
  logic [8:0] err_sum;

  always_comb begin
    err_sum     = {1'b0, err_count_q} + 9'(frame_err_q) + 9'(overrun_pulse);
    err_count_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_serial2parallel.sv
// Directed scoreboard bench for serial2parallel; drives an MSB-first and an LSB-first instance in lockstep.
module tb_serial2parallel;
  import p2s_pkg::*;

  logic clk;
  logic rst;
  int   check_cnt;
  int   pass_cnt;
  int   fe_seen;
  int   ov_seen;
  int   fe_mark;
  int   ov_mark;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  logic [7:0] exp_word;

  serial2parallel_if #(.WIDTH(8)) bus_m ();
  serial2parallel_if #(.WIDTH(8)) bus_l ();

`ifdef SERIAL2PARALLEL_ERR_CNT_EN
  logic [7:0] err_count_m;
  logic [7:0] err_count_l;
`endif

  serial2parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
`ifdef SERIAL2PARALLEL_ERR_CNT_EN
    , .err_count (err_count_m)
`endif
  );

  serial2parallel #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
`ifdef SERIAL2PARALLEL_ERR_CNT_EN
    , .err_count (err_count_l)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] reverse8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Drive one cycle; words accepted at the coming edge are popped from the scoreboards.
  task automatic applyStimulus(input logic s, input logic b, input logic e, input logic r);
    bus_m.serial_start = s; bus_m.serial_in = b; bus_m.serial_end = e; bus_m.out_ready = r;
    bus_l.serial_start = s; bus_l.serial_in = b; bus_l.serial_end = e; bus_l.out_ready = r;
    if (bus_m.out_valid && bus_m.out_ready) begin
      checkOutput("sb_msb_has_entry", 32'(q_m.size() > 0), 32'd1);
      if (q_m.size() > 0) begin
        exp_word = q_m.pop_front();
        checkOutput("word_msb", 32'(bus_m.parallel_out), 32'(exp_word));
      end
    end
    if (bus_l.out_valid && bus_l.out_ready) begin
      checkOutput("sb_lsb_has_entry", 32'(q_l.size() > 0), 32'd1);
      if (q_l.size() > 0) begin
        exp_word = q_l.pop_front();
        checkOutput("word_lsb", 32'(bus_l.parallel_out), 32'(exp_word));
      end
    end
    fe_seen += int'(bus_m.frame_err);
    ov_seen += int'(bus_m.overrun);
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] w, input logic r, input bit push);
    if (push) begin
      q_m.push_back(w);
      q_l.push_back(reverse8(w));
    end
    for (int i = 7; i >= 0; i--) applyStimulus(i == 7, w[i], i == 0, r);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, r);
  endtask

  initial begin
    check_cnt = 0; pass_cnt = 0; fe_seen = 0; ov_seen = 0;
    rst = 1'b1;
    bus_m.serial_start = 0; bus_m.serial_in = 0; bus_m.serial_end = 0; bus_m.out_ready = 0;
    bus_l.serial_start = 0; bus_l.serial_in = 0; bus_l.serial_end = 0; bus_l.out_ready = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_out_valid", 32'(bus_m.out_valid), 32'd0);
    checkOutput("rst_parallel_out", 32'(bus_m.parallel_out), 32'd0);
    checkOutput("rst_frame_err", 32'(bus_m.frame_err), 32'd0);
    checkOutput("rst_overrun", 32'(bus_m.overrun), 32'd0);
`ifdef SERIAL2PARALLEL_ERR_CNT_EN
    checkOutput("rst_err_count", 32'(err_count_m), 32'd0);
`endif

    $display("[TB] basic frame D3");
    fe_mark = fe_seen;
    sendFrame(8'hD3, 1'b1, 1'b1);
    checkOutput("basic_valid", 32'(bus_m.out_valid), 32'd1);
    checkOutput("basic_word", 32'(bus_m.parallel_out), 32'hD3);
    checkOutput("lsb_first_word", 32'(bus_l.parallel_out), 32'hCB);
    idle(1, 1'b1);
    checkOutput("basic_valid_clear", 32'(bus_m.out_valid), 32'd0);
    checkOutput("basic_no_frame_err", 32'(fe_seen - fe_mark), 32'd0);

    $display("[TB] back-to-back D3 5A");
    sendFrame(8'hD3, 1'b1, 1'b1);
    sendFrame(8'h5A, 1'b1, 1'b1);
    idle(2, 1'b1);
    checkOutput("b2b_drained", 32'(q_m.size()), 32'd0);

    $display("[TB] backpressure D3 then A5");
    ov_mark = ov_seen;
    sendFrame(8'hD3, 1'b0, 1'b1);
    sendFrame(8'hA5, 1'b0, 1'b0);
    idle(2, 1'b0);
    checkOutput("bp_held_word", 32'(bus_m.parallel_out), 32'hD3);
    checkOutput("bp_still_valid", 32'(bus_m.out_valid), 32'd1);
    checkOutput("bp_overrun_once", 32'(ov_seen - ov_mark), 32'd1);
    idle(1, 1'b1);
    checkOutput("bp_valid_clear", 32'(bus_m.out_valid), 32'd0);
    checkOutput("bp_drained", 32'(q_m.size()), 32'd0);

    $display("[TB] early serial_end");
    fe_mark = fe_seen;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    checkOutput("early_end_err", 32'(fe_seen - fe_mark), 32'd1);
    checkOutput("early_end_no_valid", 32'(bus_m.out_valid), 32'd0);

    $display("[TB] serial_start mid-frame");
    fe_mark = fe_seen;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    sendFrame(8'h96, 1'b1, 1'b1);
    idle(2, 1'b1);
    checkOutput("restart_err", 32'(fe_seen - fe_mark), 32'd1);
    checkOutput("restart_drained", 32'(q_m.size()), 32'd0);

    $display("[TB] missing serial_end");
    fe_mark = fe_seen;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'(i % 2), 1'b0, 1'b1);
    idle(2, 1'b1);
    checkOutput("no_end_err", 32'(fe_seen - fe_mark), 32'd1);
    checkOutput("no_end_no_valid", 32'(bus_m.out_valid), 32'd0);

    $display("[TB] stray serial_end in idle");
    fe_mark = fe_seen;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1);
    checkOutput("idle_end_errs", 32'(fe_seen - fe_mark), 32'd2);
`ifdef SERIAL2PARALLEL_ERR_CNT_EN
    checkOutput("err_count_total", 32'(err_count_m), 32'd6);
`endif

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
`ifdef SERIAL2PARALLEL_ERR_CNT_EN
    checkOutput("err_count_after_rst", 32'(err_count_m), 32'd0);
`endif
    sendFrame(8'h3C, 1'b1, 1'b1);
    checkOutput("rst_frame_word", 32'(bus_m.parallel_out), 32'h3C);
    idle(2, 1'b1);
    checkOutput("final_drained_msb", 32'(q_m.size()), 32'd0);
    checkOutput("final_drained_lsb", 32'(q_l.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/serial2parallel.md
Name: serial2parallel

Overview:
- Downstream stage of the team's parallel2serial serializer.
- Consumes the framed bit stream `serial_start` / `serial_out` / `serial_end` and reassembles it into WIDTH-bit words.
- Presents each word on a valid/ready output port and flags framing errors and overruns.
- Together with the serializer it forms the loopback pair used in the lab4 sequential exercises.

Parameters:
- WIDTH, 8, word size in bits; frame length; must be >= 2.
- MSB_FIRST, 1, 1: first serial bit lands in parallel_out[WIDTH-1]; 0: first bit lands in parallel_out[0].

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- serial_start  in  1  high on the cycle carrying the first bit of a frame.
- serial_in  in  1  data bit; sampled every cycle while a frame is open.
- serial_end  in  1  high on the cycle carrying the last bit of a frame.
- parallel_out  out  WIDTH  assembled word; stable while out_valid=1.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- frame_err  out  1  one-cycle pulse on a framing violation.
- overrun  out  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, bit counter=0, shift register=0, parallel_out=0, out_valid=0, frame_err=0, overrun=0.
- Reset mid-frame discards the partial word. Reset while out_valid=1 drops the held word.
- Counter width: $clog2(WIDTH+1). Shift register width: WIDTH.
- Bit placement: MSB_FIRST=1 shifts left, inserting at bit 0. MSB_FIRST=0 shifts right, inserting at bit WIDTH-1.
- State IDLE:
  - serial_start=1 with serial_end=0: capture serial_in, cnt=1, go to SHIFT.
  - serial_start=1 with serial_end=1: frame_err pulse, stay in IDLE.
  - serial_end=1 alone: frame_err pulse.
  - serial_in is ignored otherwise.
- State SHIFT, per cycle:
  - serial_start=1: frame_err pulse. Restart the frame with the current bit (cnt=1). serial_start takes priority over serial_end.
  - Else capture serial_in and increment cnt.
  - If serial_end=1 and this bit is bit WIDTH-1: frame complete, go to IDLE.
  - If serial_end=1 and it is not bit WIDTH-1: frame_err pulse, discard the word, go to IDLE.
  - If bit WIDTH-1 is captured with serial_end=0: frame_err pulse, discard the word, go to IDLE.
- Completion and output handshake:
  - On completion, the word is loaded into parallel_out and out_valid=1 on the next cycle. Latency is 1 clk after the serial_end bit.
  - out_valid clears the cycle after out_valid & out_ready.
  - If completion coincides with out_valid=1 and out_ready=1: the new word replaces the old one and out_valid stays 1.
  - If completion coincides with out_valid=1 and out_ready=0: the new word is dropped, parallel_out is unchanged, and overrun pulses the next cycle.
- Back-to-back frames: serial_start may arrive the cycle after serial_end with no idle gap.
- The block never stalls the serial input; there is no backpressure to the serializer.

Optional Feature:
- Macro: SERIAL2PARALLEL_ERR_CNT_EN.
- Defined:
  - Adds output port err_count[7:0].
  - err_count increments on every frame_err or overrun pulse and saturates at 255.
  - If both pulse in the same cycle, it increments by 2, still saturating.
  - Resets to 0.
- Undefined: no err_count port or logic. All other behaviour is identical.

Decomposition:
- Shared package `p2s_pkg`:
  - State enum IDLE/SHIFT.
  - DEFAULT_WIDTH = 8.
  - Counter-width function.
  - Shared with parallel2serial.
- Sub-module `s2p_out_reg`: holds the one-entry output register, the valid/ready handshake and overrun detection.
- The top level holds the framing FSM and the shift register.

Test Plan:
- Basic frame: reset, then an MSB-first frame of 8'b11010011 (start on bit 1, end on bit 8) with out_ready=1 → parallel_out=8'hD3 and out_valid=1 one cycle after serial_end, then 0. frame_err=0.
- Bit order: MSB_FIRST=0 with the same bit sequence → parallel_out=8'hCB.
- Back-to-back: 8'hD3 then 8'h5A with no gap, out_ready=1 → two consecutive valid words, D3 then 5A.
- Backpressure: out_ready=0 across 8'hD3 then 8'hA5 → parallel_out stays D3 and overrun pulses once. Raising out_ready then gives one accept, then out_valid=0.
- Framing errors:
  - serial_end on the 5th bit → frame_err pulse and no out_valid.
  - serial_start mid-frame, then 8 good bits → one frame_err and correct word delivery.
  - 8 bits with no serial_end → frame_err.
- Reset mid-frame: rst after 4 bits, then a full 8'h3C frame → only 8'h3C is delivered. With SERIAL2PARALLEL_ERR_CNT_EN, err_count=0 after reset and counts each injected error.
